// File: rtl/vec_square_if.sv
// Handshake bundle for vec_square_pipe: input beat channel and output result channel.
// The unit uses the slave modport and the beat source/sink uses the master modport.
interface vec_square_if #(
  parameter int WIDTH = 32,
  parameter int CH    = 3,
  parameter int TAG_W = 8
);
  localparam int SUM_W = (WIDTH + $clog2(CH) > WIDTH + 1) ? WIDTH + $clog2(CH) : WIDTH + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [CH*WIDTH-1:0]   in_data;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [CH*WIDTH-1:0]   square_out;
  logic [SUM_W-1:0]      sumsq_out;
  logic [TAG_W-1:0]      tag_out;
  logic                  ovf_out;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, square_out, sumsq_out, tag_out, ovf_out
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, square_out, sumsq_out, tag_out, ovf_out
  );
endinterface

// File: rtl/vec_square_pipe.sv
// Pipelined multi-lane fixed-point squarer with |v|^2 sum, tag sideband and global stall.
// Define VEC_SQUARE_SAT_EN to saturate overflowing lanes and report them on ovf_out.
module vec_square_pipe #(
  parameter int WIDTH  = 32,
  parameter int Q_BITS = 16,
  parameter int CH     = 3,
  parameter int LAT    = 2,
  parameter int TAG_W  = 8
) (
  input  logic         clk,
  input  logic         reset,
  vec_square_if.slave  bus
);
  localparam int SUM_W = (WIDTH + $clog2(CH) > WIDTH + 1) ? WIDTH + $clog2(CH) : WIDTH + 1;
  localparam int PW    = 2*WIDTH + 1;
  localparam logic [PW-1:0] HALF = PW'(1) << (Q_BITS - 1);

  // Full-precision square, rounded half up back to Q format; PW bits hold the
  // largest square (-2^(WIDTH-1))^2 plus the rounding constant.
  function automatic logic [PW-1:0] square_round(input logic signed [WIDTH-1:0] a);
    logic signed [2*WIDTH-1:0] a_ext;
    logic        [2*WIDTH-1:0] p;
    a_ext = a;
    p     = a_ext * a_ext;
    return ({1'b0, p} + HALF) >> Q_BITS;
  endfunction

`ifdef VEC_SQUARE_SAT_EN
  // Returns {overflow, lane}; overflow means r does not fit the positive lane range.
  function automatic logic [WIDTH:0] saturate(input logic [PW-1:0] r);
    logic ovf;
    ovf = |r[PW-1:WIDTH-1];
    return ovf ? {1'b1, 1'b0, {(WIDTH-1){1'b1}}} : {1'b0, r[WIDTH-1:0]};
  endfunction
`endif

  logic stall;
  logic accept;

  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall & ~reset;
  assign accept       = bus.in_valid & bus.in_ready;

  logic [CH*WIDTH-1:0] lane_res;
`ifdef VEC_SQUARE_SAT_EN
  logic [CH-1:0]       lane_ovf;
`endif

  always_comb begin
    lane_res = '0;
`ifdef VEC_SQUARE_SAT_EN
    lane_ovf = '0;
`endif
    for (int i = 0; i < CH; i++) begin
`ifdef VEC_SQUARE_SAT_EN
      {lane_ovf[i], lane_res[i*WIDTH +: WIDTH]} =
        saturate(square_round(bus.in_data[i*WIDTH +: WIDTH]));
`else
      lane_res[i*WIDTH +: WIDTH] = WIDTH'(square_round(bus.in_data[i*WIDTH +: WIDTH]));
`endif
    end
  end

  // ---- stage 1: per-lane squares registered ----
  logic                vld_p1;
  logic [CH*WIDTH-1:0] sq_p1;
  logic [TAG_W-1:0]    tag_p1;
  logic [SUM_W-1:0]    sum_p1;

  always_comb begin
    sum_p1 = '0;
    for (int i = 0; i < CH; i++)
      sum_p1 = sum_p1 + SUM_W'(sq_p1[i*WIDTH +: WIDTH]);
  end

  // ---- stage 2 (sum registered) and stages 3..LAT (retiming delay) ----
  logic                vld_pn [2:LAT];
  logic [CH*WIDTH-1:0] sq_pn  [2:LAT];
  logic [SUM_W-1:0]    sum_pn [2:LAT];
  logic [TAG_W-1:0]    tag_pn [2:LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      sq_p1  <= '0;
      tag_p1 <= '0;
      for (int k = 2; k <= LAT; k++) begin
        vld_pn[k] <= 1'b0;
        sq_pn[k]  <= '0;
        sum_pn[k] <= '0;
        tag_pn[k] <= '0;
      end
    end else if (!stall) begin
      vld_p1    <= accept;
      sq_p1     <= lane_res;
      tag_p1    <= bus.in_tag;
      vld_pn[2] <= vld_p1;
      sq_pn[2]  <= sq_p1;
      sum_pn[2] <= sum_p1;
      tag_pn[2] <= tag_p1;
      for (int k = 3; k <= LAT; k++) begin
        vld_pn[k] <= vld_pn[k-1];
        sq_pn[k]  <= sq_pn[k-1];
        sum_pn[k] <= sum_pn[k-1];
        tag_pn[k] <= tag_pn[k-1];
      end
    end
  end

  assign bus.out_valid  = vld_pn[LAT];
  assign bus.square_out = sq_pn[LAT];
  assign bus.sumsq_out  = sum_pn[LAT];
  assign bus.tag_out    = tag_pn[LAT];

`ifdef VEC_SQUARE_SAT_EN
  logic ovf_p1;
  logic ovf_pn [2:LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_p1 <= 1'b0;
      for (int k = 2; k <= LAT; k++) ovf_pn[k] <= 1'b0;
    end else if (!stall) begin
      ovf_p1    <= |lane_ovf;
      ovf_pn[2] <= ovf_p1;
      for (int k = 3; k <= LAT; k++) ovf_pn[k] <= ovf_pn[k-1];
    end
  end

  assign bus.ovf_out = ovf_pn[LAT];
`else
  assign bus.ovf_out = 1'b0;
`endif

endmodule

// File: tb/tb_vec_square_pipe.sv
// Self-checking bench for vec_square_pipe: behavioural model with scoreboard plus directed literals.
module tb_vec_square_pipe;
  localparam int WIDTH = 32, Q_BITS = 16, CH = 3, LAT = 2, TAG_W = 8, SUM_W = 34;
`ifdef VEC_SQUARE_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vec_square_if #(.WIDTH(WIDTH), .CH(CH), .TAG_W(TAG_W)) bus ();

  vec_square_pipe #(.WIDTH(WIDTH), .Q_BITS(Q_BITS), .CH(CH), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic [CH*WIDTH-1:0] sq;
    logic [SUM_W-1:0]    sum;
    logic [TAG_W-1:0]    tag;
    logic                ovf;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0, failures = 0, n_out = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Square in real Q16.16 terms: (a^2 + 0.5 ulp) / 2^16, floored.
  function automatic logic [WIDTH-1:0] model_lane(input logic [WIDTH-1:0] a, output logic ovf);
    longint s, r;
    s   = longint'($signed(a));
    r   = (s * s + 64'sd32768) / 64'sd65536;
    ovf = (r > 64'sd2147483647);
    if (ovf && SAT_ON) return 32'h7FFFFFFF;
    return r[31:0];
  endfunction

  function automatic beat_t model(input logic [CH*WIDTH-1:0] d, input logic [TAG_W-1:0] t);
    beat_t b;
    logic o;
    logic [WIDTH-1:0] l;
    b = '0;
    b.tag = t;
    for (int i = 0; i < CH; i++) begin
      l = model_lane(d[i*WIDTH +: WIDTH], o);
      b.sq[i*WIDTH +: WIDTH] = l;
      b.sum = b.sum + SUM_W'(l);
      b.ovf = b.ovf | (o & SAT_ON);
    end
    return b;
  endfunction

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  beat_t prev_out;
  logic  prev_stall = 1'b0;
  always @(negedge clk) begin
    beat_t cur, e;
    cur = '{sq: bus.square_out, sum: bus.sumsq_out, tag: bus.tag_out, ovf: bus.ovf_out};
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", bus.out_valid, 1'b1);
        chk("stall_data_held", cur, prev_out);
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_data, bus.in_tag));
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", bus.tag_out, 9'h1FF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_square", cur.sq, e.sq);
          chk("sb_sumsq", cur.sum, e.sum);
          chk("sb_tag", cur.tag, e.tag);
          chk("sb_ovf", cur.ovf, e.ovf);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = cur;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a beat and hold it until accepted; in_valid is left high.
  task automatic push_beat(input logic [CH*WIDTH-1:0] d, input logic [TAG_W-1:0] t);
    logic acc;
    int   guard;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_tag   = t;
    acc = 1'b0;
    guard = 0;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      guard++;
      if (guard > 500) begin
        chk("accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
  endtask

  // Single beat into an empty pipeline with out_ready high; checks exact latency and values.
  task automatic run_directed(input string nm, input logic [CH*WIDTH-1:0] d, input logic [TAG_W-1:0] t,
                              input logic [CH*WIDTH-1:0] esq, input logic [SUM_W-1:0] esum, input logic eovf);
    push_beat(d, t);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_early_valid"}, bus.out_valid, 1'b0);
    step();
    @(negedge clk);
    chk({nm, "_valid"}, bus.out_valid, 1'b1);
    chk({nm, "_square"}, bus.square_out, esq);
    chk({nm, "_sumsq"}, bus.sumsq_out, esum);
    chk({nm, "_tag"}, bus.tag_out, t);
    chk({nm, "_ovf"}, bus.ovf_out, eovf);
    step();
  endtask

  function automatic logic [WIDTH-1:0] rand_lane();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: begin
        v = $urandom_range(0, 32'h001FFFFF);
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      2: v = 32'h80000000;
      default: v = $urandom_range(0, 255);
    endcase
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic o;
    int   base, g;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_square", bus.square_out, '0);
    chk("rst_sumsq", bus.sumsq_out, '0);
    chk("rst_tag", bus.tag_out, '0);
    chk("rst_ovf", bus.ovf_out, 1'b0);
    step();
    reset = 1'b0;
    step();

    // Hand-computed values that pin the reference model.
    chk("pin_b6", model_lane(32'h000000B6, o), 32'h1);
    chk("pin_b5", model_lane(32'h000000B5, o), 32'h0);
    chk("pin_100", model_lane(32'h00000100, o), 32'h1);
    chk("pin_neg2", model_lane(32'hFFFE0000, o), 32'h00040000);
    chk("pin_256", model_lane(32'h01000000, o), SAT_ON ? 32'h7FFFFFFF : 32'h0);
    chk("pin_min", model_lane(32'h80000000, o), SAT_ON ? 32'h7FFFFFFF : 32'h0);

    run_directed("vec", {32'h00008000, 32'hFFFE0000, 32'h00018000}, 8'h5A,
                 {32'h00004000, 32'h00040000, 32'h00024000}, 34'h68000, 1'b0);
    run_directed("round", {32'h00000100, 32'h000000B5, 32'h000000B6}, 8'h11,
                 {32'h00000001, 32'h00000000, 32'h00000001}, 34'h2, 1'b0);
    run_directed("zero_neg", {32'h00000000, 32'hFFFF8000, 32'h00008000}, 8'h22,
                 {32'h00000000, 32'h00004000, 32'h00004000}, 34'h8000, 1'b0);
`ifdef VEC_SQUARE_SAT_EN
    run_directed("ovf", {32'h00000000, 32'h80000000, 32'h01000000}, 8'h33,
                 {32'h00000000, 32'h7FFFFFFF, 32'h7FFFFFFF}, 34'hFFFFFFFE, 1'b1);
`else
    run_directed("ovf", {32'h00000000, 32'h80000000, 32'h01000000}, 8'h33,
                 {32'h00000000, 32'h00000000, 32'h00000000}, 34'h0, 1'b0);
`endif

    // Back-to-back random stream with random backpressure.
    base = n_out;
    fork
      begin
        for (int k = 0; k < 20; k++)
          push_beat({rand_lane(), rand_lane(), rand_lane()}, 8'(k + 8'h80));
        bus.in_valid = 1'b0;
      end
      begin
        g = 0;
        while (n_out < base + 20 && g < 2000) begin
          bus.out_ready = ($urandom_range(0, 1) == 1);
          step();
          g++;
        end
        bus.out_ready = 1'b1;
      end
    join
    repeat (4) step();
    chk("stream_count", n_out - base, 20);
    chk("stream_drained", exp_q.size(), 0);

    // Reset with two beats in flight.
    bus.out_ready = 1'b0;
    push_beat({32'h00010000, 32'h00020000, 32'h00030000}, 8'hE1);
    push_beat({32'h00040000, 32'h00050000, 32'h00060000}, 8'hE2);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", bus.in_ready, 1'b0);
    step();
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_in_ready2", bus.in_ready, 1'b0);
    chk("midrst_square", bus.square_out, '0);
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    base = n_out;
    run_directed("post_rst", {32'h00000000, 32'h00000000, 32'h00020000}, 8'hC3,
                 {32'h00000000, 32'h00000000, 32'h00040000}, 34'h40000, 1'b0);
    repeat (5) step();
    chk("post_rst_count", n_out - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
